// File: rtl/ram16x4_pkg.sv
// Shared defaults and FSM encoding for the ram16x4 arbiter.
package ram16x4_pkg;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/ram16x4_arbiter_if.sv
// Two-port request/grant bus of the ram16x4 arbiter; busy rides along as a status line.
interface ram16x4_arbiter_if #(
  parameter int DATA_WIDTH = ram16x4_pkg::DATA_WIDTH_DEF,
  parameter int DEPTH      = ram16x4_pkg::DEPTH_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic [AW-1:0]         addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  gnt_a, gnt_b;
  logic                  rvalid_a, rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  busy;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy
  );
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy
  );
endinterface

// File: rtl/ram16x4_rr_pick.sv
// Two-way round-robin pick; last_b remembers whether B was served most recently.
module ram16x4_rr_pick (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_b;

  assign gnt_a = en & req_a & (~req_b | last_b);
  assign gnt_b = en & req_b & (~req_a | ~last_b);

  // Reset to "B served last" so A wins the first conflict.
  always_ff @(posedge clk or posedge rst)
    if (rst)                last_b <= 1'b1;
    else if (gnt_a | gnt_b) last_b <= gnt_b;
endmodule

// File: rtl/ram16x4_arbiter.sv
// Single-port DEPTH x DATA_WIDTH RAM shared by two requesters with round-robin arbitration.
// Define RAM16X4_ARB_INIT_EN to zero the array after reset (busy during the sweep).
module ram16x4_arbiter
  import ram16x4_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  ram16x4_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic                  run;
  logic                  acc_we;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM16X4_ARB_INIT_EN
  state_t        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
        sweep_d = '0;
      end
    end
  end

  assign run      = (state_q == RUN);
  assign bus.busy = (state_q == INIT);
`else
  assign run      = 1'b1;
  assign bus.busy = 1'b0;
`endif

  ram16x4_rr_pick u_pick (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (bus.gnt_a),
    .gnt_b (bus.gnt_b)
  );

  // One shared access port: sweep owns it in INIT, else the granted requester.
  always_comb begin
    acc_we    = (bus.gnt_a & bus.we_a) | (bus.gnt_b & bus.we_b);
    acc_addr  = bus.gnt_b ? bus.addr_b  : bus.addr_a;
    acc_wdata = bus.gnt_b ? bus.wdata_b : bus.wdata_a;
`ifdef RAM16X4_ARB_INIT_EN
    if (!run) begin
      acc_we    = 1'b1;
      acc_addr  = sweep_q;
      acc_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk)
    if (acc_we) mem[acc_addr] <= acc_wdata;

  assign rd_word = mem[acc_addr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;
      bus.rdata_a  <= '0;
      bus.rdata_b  <= '0;
    end else begin
      bus.rvalid_a <= bus.gnt_a & ~bus.we_a;
      bus.rvalid_b <= bus.gnt_b & ~bus.we_b;
      if (bus.gnt_a & ~bus.we_a) bus.rdata_a <= rd_word;
      if (bus.gnt_b & ~bus.we_b) bus.rdata_b <= rd_word;
    end
endmodule

// File: doc/ram16x4_arbiter.md
RAM16X4_ARBITER -- requirements
Module: ram16x4_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; AW = $clog2(DEPTH).
REQ-003 SHALL have a single clock and an asynchronous, active-high reset, clk and rst, with all state on clk rising edge.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports req_a / req_b  input  1  access request, held until granted.
REQ-007 SHALL have ports we_a / we_b  input  1  1 = write, 0 = read; valid while req high.
REQ-008 SHALL have ports addr_a / addr_b  input  AW  word address.
REQ-009 SHALL have ports wdata_a / wdata_b  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports gnt_a / gnt_b  output  1  combinational; access performed at this clock edge.
REQ-011 SHALL have ports rvalid_a / rvalid_b  output  1  one-cycle pulse; read data valid.
REQ-012 SHALL have ports rdata_a / rdata_b  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port busy  output  1  high while initialisation sweep runs; no grants are issued.

Function
REQ-014 SHALL contain internal single-port storage of DEPTH x DATA_WIDTH, at most one access per cycle.
REQ-015 SHALL run FSM states INIT (zeroing sweep) and RUN; INIT -> RUN after the word at DEPTH-1 is written.
REQ-016 SHALL, in INIT, write 0 to one address per cycle from 0 to DEPTH-1, with busy=1 and gnt_a=gnt_b=0.
REQ-017 SHALL, in RUN with exactly one req high, grant that requester in the same cycle.
REQ-018 SHALL, in RUN with both req high, grant the requester not served last (round-robin); the last-served register updates only on a grant.
REQ-019 SHALL never assert gnt_a and gnt_b in the same cycle.
REQ-020 SHALL, on a granted write, update the storage at that edge; rvalid stays low.
REQ-021 SHALL, on a granted read, register the data into rdata_x and pulse rvalid_x in the following cycle (latency 1).
REQ-022 SHALL hold rdata_x stable until that port's next read completes.
REQ-023 SHALL return the new data on a read granted the cycle after a write to the same address.
REQ-024 SHALL allow an ungranted requester's fields to change only after gnt; behaviour with req dropped before gnt: request withdrawn, no access.

Reset
REQ-025 SHALL, on rst, clear gnt, rvalid and rdata of both ports to 0 and set last-served = B, so A wins the first conflict.
REQ-026 SHALL reset busy to 1 and the FSM to INIT with sweep address 0 when RAM16X4_ARB_INIT_EN is defined, else busy=0 and FSM=RUN.
REQ-027 SHALL, on reset mid-operation, drop any pending rvalid and restart the sweep (if enabled) from address 0.

Configuration
REQ-028 SHALL, with macro RAM16X4_ARB_INIT_EN defined, include the INIT sweep: DEPTH cycles of busy after reset, with all words reading 0.
REQ-029 SHALL, without RAM16X4_ARB_INIT_EN, omit INIT: busy is tied 0, grants are possible in the first cycle after reset, and contents are undefined until written.

Structure
REQ-030 SHALL place DATA_WIDTH/DEPTH defaults and the FSM state encoding (INIT, RUN) in shared package ram16x4_pkg.
REQ-031 SHALL implement the two-way round-robin pick, including the last-served register, in sub-module ram16x4_rr_pick.

Verification
REQ-032 SHALL cover: with INIT_EN, release rst and hold req_a -> busy high 16 cycles, gnt_a on cycle 17; read addr 7 -> rdata_a=0.
REQ-033 SHALL cover: A writes 0xA at addr 3, then A reads addr 3 -> gnt_a each cycle, rvalid_a one cycle after the read grant, rdata_a=0xA.
REQ-034 SHALL cover: both req held continuously, A write addr 5=0xC, B read addr 5 -> gnt_a first, then gnt_b, rdata_b=0xC.
REQ-035 SHALL cover: both req held 6 cycles -> grants alternate A,B,A,B,A,B; never both high.
REQ-036 SHALL cover: rst asserted the cycle after a read grant -> rvalid stays 0, rdata=0, sweep restarts.
REQ-037 SHALL cover: without INIT_EN, write 0x3 at addr 15 then read it in the first RUN cycles -> rdata=0x3, busy constant 0.
